// File: rtl/sram_pkg.sv
// Shared constants for the SRAM request path: address/data widths, request bundle width
// and the SRAM slave's request-to-ack latency.
package sram_pkg;
  localparam int SRAM_AW  = 15;
  localparam int SRAM_DW  = 32;
  localparam int SRAM_LAT = 3;
  localparam int REQW     = 1 + SRAM_AW + SRAM_DW + SRAM_DW / 8;

  // Width of a {we, addr, data, sel} request bundle for arbitrary bus widths.
  function automatic int req_width(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction
endpackage

// File: rtl/sram_reqfifo.sv
// Synchronous request FIFO with occupancy count, same-cycle push/pop and a
// synchronous clear used to drop queued requests on a bus abort.
module sram_reqfifo
  import sram_pkg::*;
#(
  parameter int W  = REQW,
  parameter int LG = 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [LG:0]   o_count
);
  localparam int DEPTH = 1 << LG;
  localparam logic [LG:0] FULL = (LG + 1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [LG-1:0] wr_ptr_r;
  logic [LG-1:0] rd_ptr_r;
  logic [LG:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify push/pop against occupancy; a pop frees a slot for a same-cycle push.
  always_comb begin
    do_pop_s  = i_pop && (count_r != {(LG + 1){1'b0}});
    do_push_s = i_push && ((count_r != FULL) || do_pop_s);
  end

  // Storage array and write pointer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
      wr_ptr_r <= {LG{1'b0}};
    end else if (i_clear) begin
      wr_ptr_r <= {LG{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= i_data;
      wr_ptr_r        <= wr_ptr_r + LG'(1);
    end
  end

  // Read pointer and occupancy count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr_r <= {LG{1'b0}};
      count_r  <= {(LG + 1){1'b0}};
    end else if (i_clear) begin
      rd_ptr_r <= {LG{1'b0}};
      count_r  <= {(LG + 1){1'b0}};
    end else begin
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + LG'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (LG + 1)'(1);
        2'b01:   count_r <= count_r - (LG + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign o_data  = mem_r[rd_ptr_r];
  assign o_count = count_r;
endmodule

// File: rtl/sram_wbqueue.sv
// Pipelined Wishbone request queue in front of the SRAM slave: buffers requests, issues them
// one at a time, returns acks in order and flushes on a CYC drop.
module sram_wbqueue
  import sram_pkg::*;
#(
  parameter int AW     = SRAM_AW,
  parameter int DW     = SRAM_DW,
  parameter int LGFIFO = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [DW-1:0]     i_wb_data,
  input  logic [DW/8-1:0]   i_wb_sel,
  output logic              o_wb_ack,
  output logic              o_wb_stall,
  output logic [DW-1:0]     o_wb_data,
  output logic              o_dn_cyc,
  output logic              o_dn_stb,
  output logic              o_dn_we,
  output logic [AW-1:0]     o_dn_addr,
  output logic [DW-1:0]     o_dn_data,
  output logic [DW/8-1:0]   o_dn_sel,
  input  logic              i_dn_ack,
  input  logic              i_dn_stall,
  input  logic [DW-1:0]     i_dn_data
);
  localparam int REQ_W = req_width(AW, DW);
  localparam int CW    = LGFIFO + 1;
  localparam logic [CW-1:0] LIMIT = CW'(1 << LGFIFO);

  logic [CW-1:0]    nout_r;
  logic             flush_r;
  logic             cyc_d_r;
  logic [CW-1:0]    fifo_cnt_s;
  logic [CW-1:0]    fcnt_s;
  logic [CW-1:0]    occ_s;
  logic [REQ_W-1:0] in_req_s;
  logic [REQ_W-1:0] fifo_head_s;
  logic [REQ_W-1:0] head_s;
  logic             fifo_empty_s;
  logic             accept_s;
  logic             can_issue_s;
  logic             issue_s;
  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic             dn_take_s;
  logic             ack_fwd_s;

  // The request parked on o_dn_stb still counts as queued, so the limit bounds true in-flight work.
  always_comb begin
    fcnt_s       = fifo_cnt_s + CW'(o_dn_stb);
    occ_s        = fcnt_s + nout_r;
    o_wb_stall   = flush_r || (occ_s == LIMIT);
    accept_s     = i_wb_cyc && i_wb_stb && !o_wb_stall;
    in_req_s     = {i_wb_we, i_wb_addr, i_wb_data, i_wb_sel};
    fifo_empty_s = (fifo_cnt_s == CW'(0));
    can_issue_s  = !o_dn_stb || !i_dn_stall;
    issue_s      = i_wb_cyc && can_issue_s && (!fifo_empty_s || accept_s);
    if (fifo_empty_s) begin
      head_s = in_req_s;
    end else begin
      head_s = fifo_head_s;
    end
    fifo_pop_s  = issue_s && !fifo_empty_s;
    fifo_push_s = accept_s && !(issue_s && fifo_empty_s);
    dn_take_s   = o_dn_stb && !i_dn_stall;
    ack_fwd_s   = i_dn_ack && i_wb_cyc && o_dn_cyc && (nout_r != CW'(0));
  end

  sram_reqfifo #(
    .W  (REQ_W),
    .LG (LGFIFO)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (!i_wb_cyc),
    .i_push    (fifo_push_s),
    .i_data    (in_req_s),
    .i_pop     (fifo_pop_s),
    .o_data    (fifo_head_s),
    .o_count   (fifo_cnt_s)
  );

  // Downstream request register; fields hold while the slave stalls.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dn_stb  <= 1'b0;
      o_dn_we   <= 1'b0;
      o_dn_addr <= {AW{1'b0}};
      o_dn_data <= {DW{1'b0}};
      o_dn_sel  <= {(DW / 8){1'b0}};
    end else if (!i_wb_cyc) begin
      o_dn_stb <= 1'b0;
    end else if (issue_s) begin
      o_dn_stb <= 1'b1;
      {o_dn_we, o_dn_addr, o_dn_data, o_dn_sel} <= head_s;
    end else if (!i_dn_stall) begin
      o_dn_stb <= 1'b0;
    end
  end

  // Outstanding-request counter, cleared on abort.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      nout_r <= CW'(0);
    end else if (!i_wb_cyc) begin
      nout_r <= CW'(0);
    end else begin
      case ({dn_take_s, ack_fwd_s})
        2'b10:   nout_r <= nout_r + CW'(1);
        2'b01:   nout_r <= nout_r - CW'(1);
        default: nout_r <= nout_r;
      endcase
    end
  end

  // Flush pulses for one cycle on each falling edge of upstream CYC.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cyc_d_r  <= 1'b0;
      flush_r  <= 1'b0;
      o_dn_cyc <= 1'b0;
    end else begin
      cyc_d_r  <= i_wb_cyc;
      flush_r  <= cyc_d_r && !i_wb_cyc;
      o_dn_cyc <= i_wb_cyc && !flush_r;
    end
  end

  // Upstream ack and read-data return.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= {DW{1'b0}};
    end else begin
      o_wb_ack  <= ack_fwd_s;
      o_wb_data <= i_dn_data;
    end
  end
endmodule
